// File: rtl/logic_74hc193_emu_if.sv
// -----------------------------------------------------------------------------
// logic_74hc193_emu_if
//
// Pin bundle for the 74HC193 up/down counter emulation. The chip-side control
// and count pins plus the counter outputs travel together so a cascade of
// stages can be wired as a set of interface instances.
//
// Signals:
//   mr       chip master reset, active-high, level-sensitive
//   npl      parallel load, active-low, level-sensitive
//   cpu      count-up clock pin, a rising edge counts up
//   cpd      count-down clock pin, a rising edge counts down
//   d        parallel load data
//   q        registered counter value
//   ntcu     terminal count up (carry), active-low
//   ntcd     terminal count down (borrow), active-low
//   conflict one-cycle pulse when both count pins rise in the same sample
//
// Modports:
//   master   drives the pins and observes the outputs (board / testbench side)
//   slave    the counter itself
// -----------------------------------------------------------------------------
interface logic_74hc193_emu_if #(
  parameter int unsigned Width = 4
) ();

  logic             mr;
  logic             npl;
  logic             cpu;
  logic             cpd;
  logic [Width-1:0] d;
  logic [Width-1:0] q;
  logic             ntcu;
  logic             ntcd;
  logic             conflict;

  modport master (
    output mr,
    output npl,
    output cpu,
    output cpd,
    output d,
    input  q,
    input  ntcu,
    input  ntcd,
    input  conflict
  );

  modport slave (
    input  mr,
    input  npl,
    input  cpu,
    input  cpd,
    input  d,
    output q,
    output ntcu,
    output ntcd,
    output conflict
  );

endinterface

// File: rtl/logic_74hc193_emu.sv
// -----------------------------------------------------------------------------
// logic_74hc193_emu
//
// Cycle-accurate emulation of a 74HC193 presettable binary up/down counter with
// separate up and down count pins. The count pins are ordinary data inputs
// sampled on clk_i and edge-detected; direction comes from which pin rises.
// All state is synchronous to clk_i.
//
// Parameters:
//   Width  counter width in bits (4 for the real part)
//   Init   value loaded into q on rst_ni
//
// Ports:
//   clk_i   system clock, all state updates on the rising edge
//   rst_ni  synchronous active-low reset
//   pins    logic_74hc193_emu_if.slave: mr, npl, cpu, cpd, d in;
//           q, ntcu, ntcd, conflict out
//
// Per-edge priority, highest first: rst_ni, mr, npl, count.
//
// Optional feature, macro LOGIC_74HC193_SYNC_EN:
//   When defined, cpu, cpd, mr and npl each pass through a 2-flop synchronizer
//   (reset values 1, 1, 0, 1) before any other logic, adding 2 cycles to every
//   input-to-q latency; ntcu/ntcd then use the synchronized cpu/cpd. d is not
//   synchronized, since it is only sampled while a (synchronized) load is
//   active. When undefined, the pins are used directly.
// -----------------------------------------------------------------------------
module logic_74hc193_emu #(
  parameter int unsigned     Width = 4,
  parameter logic [Width-1:0] Init  = '0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  logic_74hc193_emu_if.slave  pins
);

  localparam logic [Width-1:0] QMax = '1;
  localparam logic [Width-1:0] QOne = Width'(1);

  // Effective pin values seen by the counter core.
  logic cpu_s;
  logic cpd_s;
  logic mr_s;
  logic npl_s;

`ifdef LOGIC_74HC193_SYNC_EN
  // [0] is the first stage, [1] feeds the core.
  logic [1:0] cpu_sync_q;
  logic [1:0] cpd_sync_q;
  logic [1:0] mr_sync_q;
  logic [1:0] npl_sync_q;

  // Reset values match the idle level of each pin so leaving reset never
  // looks like an edge, a master reset or a load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cpu_sync_q <= 2'b11;
      cpd_sync_q <= 2'b11;
      mr_sync_q  <= 2'b00;
      npl_sync_q <= 2'b11;
    end else begin
      cpu_sync_q <= {cpu_sync_q[0], pins.cpu};
      cpd_sync_q <= {cpd_sync_q[0], pins.cpd};
      mr_sync_q  <= {mr_sync_q[0], pins.mr};
      npl_sync_q <= {npl_sync_q[0], pins.npl};
    end
  end

  assign cpu_s = cpu_sync_q[1];
  assign cpd_s = cpd_sync_q[1];
  assign mr_s  = mr_sync_q[1];
  assign npl_s = npl_sync_q[1];
`else
  assign cpu_s = pins.cpu;
  assign cpd_s = pins.cpd;
  assign mr_s  = pins.mr;
  assign npl_s = pins.npl;
`endif

  // Counter state and previous-cycle pin samples.
  logic [Width-1:0] q_q;
  logic [Width-1:0] q_d;
  logic             cpu_q;
  logic             cpd_q;
  logic             conflict_q;
  logic             conflict_d;

  logic up_edge;
  logic dn_edge;

  assign up_edge = cpu_s & ~cpu_q;
  assign dn_edge = cpd_s & ~cpd_q;

  // Edges seen during mr or a load are simply dropped: the pin samples still
  // advance, so nothing is remembered for after the override ends.
  always_comb begin
    q_d        = q_q;
    conflict_d = 1'b0;
    if (mr_s) begin
      q_d = '0;
    end else if (!npl_s) begin
      q_d = pins.d;
    end else if (up_edge && dn_edge) begin
      conflict_d = 1'b1;
    end else if (up_edge && cpd_s) begin
      q_d = q_q + QOne;
    end else if (dn_edge && cpu_s) begin
      q_d = q_q - QOne;
    end
    // An edge while the opposite pin is low is datasheet-illegal: hold.
  end

  // Sample registers preset to 1 so the first cycle out of reset cannot show
  // a spurious rising edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q        <= Init;
      cpu_q      <= 1'b1;
      cpd_q      <= 1'b1;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      cpu_q      <= cpu_s;
      cpd_q      <= cpd_s;
      conflict_q <= conflict_d;
    end
  end

  assign pins.q        = q_q;
  assign pins.conflict = conflict_q;

  // Combinational from q and the live (or synchronized) pin, so a cascaded
  // stage sees its carry rise together with this stage's count pin and
  // increments in the same cycle that this stage wraps.
  assign pins.ntcu = ~((q_q == QMax) & ~cpu_s);
  assign pins.ntcd = ~((q_q == '0) & ~cpd_s);

endmodule
